muldiv_unit: RTL

Iterative multiply/divide responder that owns the HI/LO register pair for the MIPS core. The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with a one-cycle Start strobe and stalls on Busy. Results land in HI/LO, which EX reads for MFHI/MFLO. This replaces single-cycle 64-bit multiply and divide with a 32-iteration radix-2 datapath.

---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit owning the HI/LO pair.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX on a one-cycle Start strobe.
// Multiply is radix-2 shift-add and divide is radix-2 restoring division.
// Both work on operand magnitudes; the sign fix-up is applied on the final
// SIGN edge, which is the only edge that writes HI/LO for mult/div.
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, a multiply leaves CALC as soon as the
//                        remaining multiplier bits are all zero. A zero
//                        multiplier skips CALC. Results are identical either way.
//
// Ports:
//   CLK, RST      clock; synchronous active-high reset (aborts any op)
//   Start         request strobe, sampled only while idle
//   Funct         function field selecting the operation
//   Rdata1        rs: multiplicand / dividend / MT* source
//   Rdata2        rt: multiplier / divisor
//   Busy          operation in flight (state != IDLE)
//   Done          one-cycle pulse after HI/LO were written by a mult/div
//   Hi, Lo        HI/LO registers
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [5:0]      Funct,
  input  logic [XLEN-1:0] Rdata1,
  input  logic [XLEN-1:0] Rdata2,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN-1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  // What the SIGN edge needs to know about the operation in flight.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder (dividend was negative)
    logic dz;      // divide by zero
  } op_t;

  state_t state, state_nxt;
  op_t    op;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand, acc_nxt;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   rem, quo, dvsr;
  logic [XLEN:0]     shifted, trial;

  // request decode
  logic            is_mul, is_div, is_sgn, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_mul = (Funct == F_MULT) || (Funct == F_MULTU);
  assign is_div = (Funct == F_DIV)  || (Funct == F_DIVU);
  assign is_sgn = (Funct == F_MULT) || (Funct == F_DIV);
  assign a_neg  = is_sgn && Rdata1[XLEN-1];
  assign b_neg  = is_sgn && Rdata2[XLEN-1];
  assign b_zero = (Rdata2 == '0);
  assign abs_a  = a_neg ? -Rdata1 : Rdata1;
  assign abs_b  = b_neg ? -Rdata2 : Rdata2;

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start && (is_mul || is_div)) begin
          if (is_div && b_zero) state_nxt = SIGN;
`ifdef MULDIV_EARLY_OUT_EN
          else if (is_mul && b_zero) state_nxt = SIGN;
`endif
          else state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) state_nxt = SIGN;
`ifdef MULDIV_EARLY_OUT_EN
        // acc_nxt already holds the full product once no multiplier bits remain
        else if (!op.is_div && mplier[XLEN-1:1] == '0) state_nxt = SIGN;
`endif
      end
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    Busy = (state != IDLE);
  end

  // One iteration of each datapath. The multiplicand is pre-shifted left, so
  // acc always holds the product of the bits consumed so far at full weight.
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  logic [2*XLEN-1:0] prod_res;
  logic [XLEN-1:0]   q_res, r_res;
  assign prod_res = op.neg_q ? -acc : acc;
  assign q_res    = op.neg_q ? -quo : quo;
  assign r_res    = op.neg_r ? -rem : rem;

  always_ff @(posedge CLK) begin
    if (RST) begin
      Hi     <= '0;
      Lo     <= '0;
      Done   <= 1'b0;
      op     <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
    end else begin
      Done <= (state == SIGN);
      case (state)
        IDLE: begin
          if (Start) begin
            if (Funct == F_MTHI) Hi <= Rdata1;
            if (Funct == F_MTLO) Lo <= Rdata1;
            if (is_mul || is_div) begin
              op.is_div <= is_div;
              op.neg_q  <= a_neg ^ b_neg;
              op.neg_r  <= a_neg;
              op.dz     <= is_div && b_zero;
              cnt       <= '0;
              acc       <= '0;
              mcand     <= {{XLEN{1'b0}}, abs_a};
              mplier    <= abs_b;
              rem       <= '0;
              // divide-by-zero returns the raw dividend in HI
              quo       <= (is_div && b_zero) ? Rdata1 : abs_a;
              dvsr      <= abs_b;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op.is_div) begin
            // restoring step: keep the difference only if it did not go negative
            if (!trial[XLEN]) begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= shifted[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        SIGN: begin
          if (!op.is_div) begin
            {Hi, Lo} <= prod_res;
          end else if (op.dz) begin
            Hi <= quo;
            Lo <= '1;
          end else begin
            Hi <= r_res;
            Lo <= q_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
